// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back/write-allocate L1 data-cache controller for the MEM stage.
// Optional macro DCACHE_STATS_EN adds saturating hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl #(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = 256,
  parameter int TAG_W     = 23
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int OFFSET_W = 5;
  localparam int WORD_W   = $clog2(LINE_W / 32);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, AL_REQ, AL_WAIT} state_e;
  state_e state_q, state_d;

  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  logic [TAG_W-1:0]   req_tag_s;
  logic [INDEX_W-1:0] index_s;
  logic [WORD_W-1:0]  word_s;
  logic [WORD_W+4:0]  bit_off_s;
  logic req_s, hit_s, idle_hit_s, hit_wr_s, wb_done_s, refill_s, miss_s;
  logic unused_s;

  assign req_tag_s = cpu_addr_i[31 -: TAG_W];
  assign index_s   = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign word_s    = cpu_addr_i[2 +: WORD_W];
  assign bit_off_s = {word_s, 5'b0_0000};
  assign req_s     = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit_s     = req_s & valid_q[index_s] & (tag_q[index_s] == req_tag_s);
  assign unused_s  = ^{cpu_addr_i[1:0], idle_hit_s, miss_s};

  always_comb begin
    state_d      = state_q;
    cpu_rdata_o  = 32'h0000_0000;
    cpu_stall_o  = 1'b0;
    mem_addr_o   = 32'h0000_0000;
    mem_wdata_o  = {LINE_W{1'b0}};
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    idle_hit_s   = 1'b0;
    hit_wr_s     = 1'b0;
    wb_done_s    = 1'b0;
    refill_s     = 1'b0;
    miss_s       = 1'b0;
    // Reset wins over every state: outputs forced to their reset values.
    if (rst_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_s) begin
            idle_hit_s = 1'b1;
            if (cpu_MemWrite_i) hit_wr_s = 1'b1;
            else                cpu_rdata_o = data_q[index_s][bit_off_s +: 32];
          end else if (req_s) begin
            cpu_stall_o = 1'b1;
            miss_s      = 1'b1;
            if (valid_q[index_s] && dirty_q[index_s]) state_d = WB_REQ;
            else                                      state_d = AL_REQ;
          end else begin
            cpu_rdata_o = 32'h0000_0000;
          end
        end
        WB_REQ, WB_WAIT: begin
          cpu_stall_o = 1'b1;
          mem_write_o = 1'b1;
          mem_addr_o  = {tag_q[index_s], index_s, 5'b0_0000};
          mem_wdata_o = data_q[index_s];
          if (state_q == WB_REQ) begin
            mem_enable_o = 1'b1;
            state_d      = WB_WAIT;
          end else if (mem_ack_i) begin
            wb_done_s = 1'b1;
            state_d   = AL_REQ;
          end else begin
            state_d = WB_WAIT;
          end
        end
        AL_REQ, AL_WAIT: begin
          cpu_stall_o = 1'b1;
          mem_addr_o  = {req_tag_s, index_s, 5'b0_0000};
          if (state_q == AL_REQ) begin
            mem_enable_o = 1'b1;
            state_d      = AL_WAIT;
          end else if (mem_ack_i) begin
            refill_s = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = AL_WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Per-line valid and dirty bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= {NUM_LINES{1'b0}};
      dirty_q <= {NUM_LINES{1'b0}};
    end else if (refill_s) begin
      valid_q[index_s] <= 1'b1;
      dirty_q[index_s] <= 1'b0;
    end else if (wb_done_s) begin
      dirty_q[index_s] <= 1'b0;
    end else if (hit_wr_s) begin
      dirty_q[index_s] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are don't-care until the line is valid
  always_ff @(posedge clk_i) begin
    if (refill_s) begin
      tag_q[index_s]  <= req_tag_s;
      data_q[index_s] <= mem_rdata_i;
    end else if (hit_wr_s) begin
      data_q[index_s][bit_off_s +: 32] <= cpu_wdata_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating counters; the hit cycle right after a refill belongs to the miss
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= 32'h0000_0000;
      miss_cnt_q <= 32'h0000_0000;
    end else begin
      refill_q <= refill_s;
      if (idle_hit_s && !refill_q && (hit_cnt_q != 32'hFFFF_FFFF))
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (miss_s && (miss_cnt_q != 32'hFFFF_FFFF))
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif
endmodule
